// File: rtl/irda_uart_pkg.sv
// Shared definitions for the UART/IrDA serial link: receiver FSM states,
// oversampling ratio and the baud-tick divider calculation.
package irda_uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clamped to 1 so an over-fast BAUD still gives a legal divider.
    function automatic int calc_div(input int clk_hz, input int baud);
        int div;
        div = clk_hz / (baud * OVERSAMPLE);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-clk tick at OVERSAMPLE x BAUD.
// Shared between the receiver and the transmitter.
module baud_tick_gen
    import irda_uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/irda_uart_rx.sv
// 8N1 receiver for an NRZ UART line or an IrDA SIR pulse line, 16x oversampled.
// Holds the last good byte and exposes it as two hex nibbles.
module irda_uart_rx
    import irda_uart_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 9600,
    parameter bit IRDA_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic [3:0] hi_nib,
    output logic [3:0] lo_nib,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic       IDLE_LEVEL = !IRDA_MODE;
    localparam logic [3:0] LAST_IDX   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_IDX    = 4'(OVERSAMPLE / 2 - 1);
    // NRZ decides at mid-bit; IrDA must watch the whole window for a pulse.
    localparam logic [3:0] DECIDE_IDX = IRDA_MODE ? LAST_IDX : MID_IDX;

    logic       rx_meta;
    logic       rx_s;
    logic       tick;
    rx_state_t  state;
    logic [3:0] sample_cnt;
    logic [3:0] next_idx;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       pulse_seen;
    logic       seen_now;
    logic       line_bit;

    baud_tick_gen #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= IDLE_LEVEL;
            rx_s    <= IDLE_LEVEL;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        next_idx = sample_cnt + 4'd1;
        seen_now = pulse_seen | rx_s;
        line_bit = IRDA_MODE ? ~seen_now : rx_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            pulse_seen <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (tick) begin
                if (state == IDLE) begin
                    // The detecting tick is sample 0 of the start-bit window.
                    pulse_seen <= rx_s;
                    if (rx_s != IDLE_LEVEL) begin
                        state      <= START;
                        sample_cnt <= '0;
                    end
                end else begin
                    sample_cnt <= next_idx;
                    pulse_seen <= (next_idx == LAST_IDX) ? 1'b0 : seen_now;
                    case (state)
                        START: begin
                            if (!IRDA_MODE && next_idx == MID_IDX && rx_s) begin
                                state <= IDLE;
                            end else if (next_idx == LAST_IDX) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                        DATA: begin
                            if (next_idx == DECIDE_IDX) begin
                                shift_reg <= {line_bit, shift_reg[7:1]};
                            end
                            if (next_idx == LAST_IDX) begin
                                if (bit_cnt == 3'd7) begin
                                    state <= STOP;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                        end
                        STOP: begin
                            if (next_idx == DECIDE_IDX) begin
                                state <= IDLE;
                                if (line_bit) begin
                                    data_out   <= shift_reg;
                                    data_valid <= 1'b1;
                                    frame_err  <= 1'b0;
                                end else begin
                                    frame_err  <= 1'b1;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign hi_nib = data_out[7:4];
    assign lo_nib = data_out[3:0];
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_irda_uart_rx.sv
// Bench for irda_uart_rx: an NRZ and an IrDA instance driven by a vector
// table, hand-written corner sequences and random frames against a byte-level model.
`timescale 1ns/1ps
module tb_irda_uart_rx;

    localparam int CLK_HZ  = 6400;
    localparam int BAUD    = 100;
    localparam int DIV     = CLK_HZ / (BAUD * 16);
    localparam int BIT_CLK = 16 * DIV;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       rx_nrz = 1'b1;
    logic       rx_ir  = 1'b0;

    logic [7:0] nrz_data, ir_data;
    logic [3:0] nrz_hi, nrz_lo, ir_hi, ir_lo;
    logic       nrz_valid, ir_valid, nrz_ferr, ir_ferr, nrz_busy, ir_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irda_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .IRDA_MODE(1'b0)) u_nrz (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_nrz),
        .data_out  (nrz_data),
        .hi_nib    (nrz_hi),
        .lo_nib    (nrz_lo),
        .data_valid(nrz_valid),
        .frame_err (nrz_ferr),
        .busy      (nrz_busy)
    );

    irda_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .IRDA_MODE(1'b1)) u_ir (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_ir),
        .data_out  (ir_data),
        .hi_nib    (ir_hi),
        .lo_nib    (ir_lo),
        .data_valid(ir_valid),
        .frame_err (ir_ferr),
        .busy      (ir_busy)
    );

    // data_valid monitor: records each pulse's byte and time, and counts pulses wider than 1 clk
    logic [7:0] nrz_q[$];
    logic [7:0] ir_q[$];
    int         nrz_wide = 0;
    int         ir_wide  = 0;
    logic       nrz_prev = 1'b0;
    logic       ir_prev  = 1'b0;
    time        nrz_vtime = 0;
    time        frame_ts  = 0;

    always @(negedge clk) begin
        if (nrz_valid) begin
            nrz_q.push_back(nrz_data);
            nrz_vtime = $time;
            if (nrz_prev) nrz_wide++;
        end
        if (ir_valid) begin
            ir_q.push_back(ir_data);
            if (ir_prev) ir_wide++;
        end
        nrz_prev = nrz_valid;
        ir_prev  = ir_valid;
    end

    // Byte-level reference: last good byte and framing flag per line type
    logic [7:0] m_last[2];
    bit         m_ferr[2];

    function automatic int model_frame(input bit ir, input logic [7:0] b, input bit stop_ok);
        if (stop_ok) begin
            m_last[ir] = b;
            m_ferr[ir] = 1'b0;
            return 1;
        end
        m_ferr[ir] = 1'b1;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold_line(input bit ir, input logic v, input int n);
        if (ir) rx_ir = v;
        else    rx_nrz = v;
        repeat (n) @(negedge clk);
    endtask

    // IrDA encodes a 0 as a 3/16-bit pulse at the start of the cell
    task automatic drive_bit(input bit ir, input logic v);
        if (!ir) begin
            hold_line(1'b0, v, BIT_CLK);
        end else if (v) begin
            hold_line(1'b1, 1'b0, BIT_CLK);
        end else begin
            hold_line(1'b1, 1'b1, 3 * DIV);
            hold_line(1'b1, 1'b0, 13 * DIV);
        end
    endtask

    task automatic send_frame(input bit ir, input logic [7:0] b, input bit stop_ok);
        frame_ts = $time;
        drive_bit(ir, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(ir, b[i]);
        if (stop_ok) begin
            drive_bit(ir, 1'b1);
        end else if (ir) begin
            drive_bit(ir, 1'b0);
        end else begin
            // Low stop released after its sample point; a full bit-time low
            // would legitimately read as the next start bit.
            hold_line(1'b0, 1'b0, 10 * DIV);
            hold_line(1'b0, 1'b1, 6 * DIV);
        end
    endtask

    task automatic idle_gap(input bit ir, input int n);
        hold_line(ir, ir ? 1'b0 : 1'b1, n);
    endtask

    task automatic check_outputs(input bit ir, input string tag,
                                 input logic [7:0] exp_data, input logic exp_ferr);
        check({tag, ".data_out"},  ir ? ir_data : nrz_data, exp_data);
        check({tag, ".hi_nib"},    ir ? ir_hi   : nrz_hi,   exp_data[7:4]);
        check({tag, ".lo_nib"},    ir ? ir_lo   : nrz_lo,   exp_data[3:0]);
        check({tag, ".frame_err"}, ir ? ir_ferr : nrz_ferr, exp_ferr);
        check({tag, ".busy"},      ir ? ir_busy : nrz_busy, 1'b0);
    endtask

    task automatic expect_valid(input bit ir, input string tag, input int n,
                                input logic [7:0] b0, input logic [7:0] b1);
        int got;
        logic [7:0] v;
        got = ir ? ir_q.size() : nrz_q.size();
        check({tag, ".n_valid"}, got, n);
        for (int k = 0; k < got && k < 2; k++) begin
            v = ir ? ir_q[k] : nrz_q[k];
            check({tag, ".valid_byte"}, v, (k == 0) ? b0 : b1);
        end
        if (ir) ir_q.delete();
        else    nrz_q.delete();
    endtask

    typedef struct {
        bit         ir;
        logic [7:0] data;
        bit         stop_ok;
        bit         glitch;
        bit         chk_time;
        logic [7:0] exp_data;
        bit         exp_ferr;
        int         exp_nvalid;
    } vec_t;

    vec_t vecs[5];

    initial begin
        string      tag;
        int         busy_seen;
        int         idx;
        int         nexp;
        bit         ir;
        bit         ok;
        logic [7:0] b;
        logic [7:0] b55;

        vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 0};
        vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 0};
        vecs[3] = '{1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 8'h7E, 1'b0, 1};
        vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1};
        m_last[0] = 8'h00; m_last[1] = 8'h00;
        m_ferr[0] = 1'b0;  m_ferr[1] = 1'b0;

        // Reset held for 3 clk with both lines idle
        repeat (3) @(negedge clk);
        check_outputs(1'b0, "reset_nrz", 8'h00, 1'b0);
        check_outputs(1'b1, "reset_ir", 8'h00, 1'b0);
        check("reset_nrz.data_valid", nrz_valid, 1'b0);
        check("reset_ir.data_valid", ir_valid, 1'b0);
        reset = 1'b0;

        busy_seen = 0;
        for (int i = 0; i < 2 * BIT_CLK; i++) begin
            @(negedge clk);
            if (nrz_busy || ir_busy) busy_seen++;
        end
        check("idle.busy_cycles", busy_seen, 0);

        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("vec%0d", i);
            if (vecs[i].glitch) begin
                hold_line(1'b0, 1'b0, 4 * DIV);
                hold_line(1'b0, 1'b1, BIT_CLK);
            end else begin
                send_frame(vecs[i].ir, vecs[i].data, vecs[i].stop_ok);
                nexp = model_frame(vecs[i].ir, vecs[i].data, vecs[i].stop_ok);
            end
            idle_gap(vecs[i].ir, 2 * BIT_CLK);
            check_outputs(vecs[i].ir, tag, vecs[i].exp_data, vecs[i].exp_ferr);
            expect_valid(vecs[i].ir, tag, vecs[i].exp_nvalid, vecs[i].exp_data, 8'h00);
            if (vecs[i].chk_time) begin
                // Stop sample falls 151 ticks after the detecting tick, which
                // lands 2..DIV+1 clk after the start edge; the pulse follows 1 clk later.
                idx = int'((nrz_vtime - frame_ts) / 10);
                check($sformatf("%s.valid_delay_%0dclk_in_window", tag, idx),
                      (idx >= 151 * DIV + 3) && (idx <= 152 * DIV + 2), 1'b1);
            end
        end

        // IrDA back-to-back frames with no idle between them
        send_frame(1'b1, 8'h00, 1'b1);
        send_frame(1'b1, 8'hFF, 1'b1);
        nexp = model_frame(1'b1, 8'h00, 1'b1);
        nexp = model_frame(1'b1, 8'hFF, 1'b1);
        idle_gap(1'b1, 2 * BIT_CLK);
        check_outputs(1'b1, "ir_b2b", 8'hFF, 1'b0);
        expect_valid(1'b1, "ir_b2b", 2, 8'h00, 8'hFF);

        // Random frames on both line types, some with a bad stop bit
        for (int i = 0; i < 12; i++) begin
            ir   = bit'(i % 2);
            b    = 8'($urandom);
            ok   = ($urandom_range(0, 3) != 0);
            tag  = $sformatf("rand%0d", i);
            nexp = model_frame(ir, b, ok);
            send_frame(ir, b, ok);
            idle_gap(ir, 2 * BIT_CLK);
            check_outputs(ir, tag, m_last[ir], m_ferr[ir]);
            expect_valid(ir, tag, nexp, b, 8'h00);
        end

        // Reset during data bit 4 of 0x55; the sender then abandons the frame
        b55 = 8'h55;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, b55[i]);
        hold_line(1'b0, b55[4], BIT_CLK / 2);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_last[0] = 8'h00; m_last[1] = 8'h00;
        m_ferr[0] = 1'b0;  m_ferr[1] = 1'b0;
        idle_gap(1'b0, 2 * BIT_CLK);
        check_outputs(1'b0, "rst_mid_nrz", m_last[0], m_ferr[0]);
        check_outputs(1'b1, "rst_mid_ir", m_last[1], m_ferr[1]);
        expect_valid(1'b0, "rst_mid_nrz", 0, 8'h00, 8'h00);
        expect_valid(1'b1, "rst_mid_ir", 0, 8'h00, 8'h00);

        send_frame(1'b0, 8'h81, 1'b1);
        nexp = model_frame(1'b0, 8'h81, 1'b1);
        idle_gap(1'b0, 2 * BIT_CLK);
        check_outputs(1'b0, "after_rst", 8'h81, 1'b0);
        expect_valid(1'b0, "after_rst", nexp, 8'h81, 8'h00);

        check("data_valid_wider_than_1clk", nrz_wide + ir_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irda_uart_rx.md
Name: irda_uart_rx

Overview:
- Serial receive front end for the UART/IrDA link.
- Recovers 8N1 bytes from either a plain NRZ UART line or an IrDA SIR pulse line, using 16x oversampling.
- Holds the last good byte and presents it as two hex nibbles, which feed the two seven-segment decoder instances directly downstream.
- Also flags completed bytes and framing errors to the board logic.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- IRDA_MODE, 1, 1 = IrDA SIR input (active-high pulse marks a 0 bit); 0 = NRZ UART input (idle high).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line from the IrDA transceiver or UART pin.
- data_out  output  8  last correctly framed byte.
- hi_nib  output  4  data_out[7:4], to the upper seven-segment decoder.
- lo_nib  output  4  data_out[3:0], to the lower seven-segment decoder.
- data_valid  output  1  one-clk pulse when data_out is updated.
- frame_err  output  1  high after a byte with a bad stop bit; cleared by the next good byte or by reset.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Interface: one clock domain, clk. Reset is synchronous and active-high, named reset.
- Reset: on a clk edge with reset=1, the following clear to 0:
  - data_out, hi_nib, lo_nib, data_valid, frame_err, busy;
  - FSM, tick divider, sample counter, bit counter, shift register.
  - Both synchronizer flops load the idle level of the line (1 for NRZ, 0 for IrDA).
- Reset mid-frame: the partial byte is discarded and no outputs pulse.
- Input sync: rx_in passes through a 2-flop synchronizer. All logic uses the second flop (rx_s). This gives 2 clk of input latency.
- Tick:
  - DIV = CLK_HZ/(BAUD*16), integer division (325 at the defaults).
  - The divider counts 0..DIV-1 and emits a 1-clk tick on DIV-1.
  - The divider free-runs; it is reset only by reset.
- Line bit:
  - NRZ mode: line bit = rx_s, sampled on a tick.
  - IrDA mode: the bit value is 0 if rx_s=1 on any tick within the 16-tick bit window, else 1. A pulse-seen flag implements this: it is set on a tick with rx_s=1 and cleared at the start of each bit window.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE, on a tick:
    - NRZ: rx_s=0 -> START with sample counter=0.
    - IrDA: rx_s=1 -> START with the pulse-seen flag set.
  - START, mid-bit check at sample counter=7:
    - NRZ: rx_s=1 there -> false start, back to IDLE, no outputs change.
    - IrDA: never a false start.
    - Otherwise, at sample counter=15 -> DATA, with bit counter=0.
  - DATA:
    - At the NRZ mid-bit sample (count 7), or at the IrDA window end (count 15), shift the line bit into the shift register, LSB first.
    - After bit 7's window ends (count 15) -> STOP.
  - STOP: at the stop-bit decision point (NRZ count 7; IrDA count 15):
    - Line bit 1 -> on the next clk, data_out <= shift register, data_valid=1 for exactly 1 clk, frame_err <= 0.
    - Line bit 0 -> on the next clk, frame_err <= 1; data_out is unchanged and there is no data_valid.
    - In both cases -> IDLE on that same next clk.
- NRZ break: an all-zero line produces a framing error, then a new start from IDLE once the line stays low.
- Back-to-back bytes: a new start bit detected on the first tick after returning to IDLE is accepted.
- Nibbles: hi_nib and lo_nib are combinational slices of the data_out register, so they change in the same clk as data_out.
- busy = (state != IDLE).

Decomposition:
- Shared package irda_uart_pkg holds:
  - FSM state encodings (2-bit localparams);
  - OVERSAMPLE=16;
  - the DIV calculation function, shared with the future transmitter.
- Sub-module baud_tick_gen (parameters CLK_HZ, BAUD; ports clk, reset, tick) is instantiated once. The transmitter reuses it.

Test Plan:
- Reset: hold reset 3 clk, with rx_in idle -> all outputs 0. Drive continuous idle for 2 bit times -> busy stays 0.
- NRZ (IRDA_MODE=0, small DIV for simulation), send 0xA5 8N1:
  - -> data_valid is a single-clk pulse, 1 clk after the stop-bit mid-sample;
  - -> data_out=0xA5, hi_nib=0xA, lo_nib=0x5, frame_err=0.
- NRZ glitch: drive rx_in low for 4 ticks, then high -> returns to IDLE, no data_valid, and data_out holds its previous value.
- NRZ framing error: send 0x3C with stop bit=0 -> frame_err=1, no data_valid, data_out unchanged. Then send 0x7E correctly -> data_out=0x7E, frame_err=0.
- IrDA (IRDA_MODE=1): send 0x3C as 3/16-bit pulses for each 0 bit, including the start bit -> data_out=0x3C, hi_nib=0x3, lo_nib=0xC. Then send 0x00 and 0xFF back-to-back -> two data_valid pulses, final data_out=0xFF.
- Reset mid-frame: assert reset during data bit 4 of 0x55 -> no data_valid, all outputs 0. The next full byte 0x81 is received correctly.
